rvx_dm_responder: RTL

// Data-memory responder on the far side of the CPU dm* master port: word-addressed RAM with byte-strobe stores, plus an MMIO window holding
// a 64-bit machine timer, timer compare/interrupt, an LED register and a sticky bus-error status. Sits at top level beside the

---
 rtl/rvx_dm_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rvx_dm_responder.sv
// rvx_dm_responder: data-memory responder behind the CPU data port.
// It provides a word-addressed RAM with byte-strobe stores and a 64-byte MMIO
// window. The window holds a 64-bit machine timer, the timer compare value and
// interrupt, an LED register and a sticky bus-error status.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   dmAddrIn     byte address; bits [1:0] are ignored for word selection
//   dmWeIn       store request this cycle
//   dmReIn       load request this cycle
//   dmDataWIn    byte strobes; bit i writes dmWDataIn[8i+7:8i]
//   dmWDataIn    lane-aligned store data
//   dmRDataOut   combinational read word; 0 when there is no load
//   timerIrqOut  registered flag, high while mtime >= mtimecmp
//   ledOut       LED register
//   busErrOut    sticky bus-error flag (STATUS bit1)
`ifndef BUS_W
`define BUS_W 32
`endif

module rvx_dm_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned LED_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`BUS_W-1:0] dmAddrIn,
  input  logic              dmWeIn,
  input  logic              dmReIn,
  input  logic [3:0]        dmDataWIn,
  input  logic [`BUS_W-1:0] dmWDataIn,
  output logic [`BUS_W-1:0] dmRDataOut,
  output logic              timerIrqOut,
  output logic [LED_W-1:0]  ledOut,
  output logic              busErrOut
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [5:0] OFF_MTIME_LO = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI = 6'h04;
  localparam logic [5:0] OFF_CMP_LO   = 6'h08;
  localparam logic [5:0] OFF_CMP_HI   = 6'h0C;
  localparam logic [5:0] OFF_LED      = 6'h10;
  localparam logic [5:0] OFF_STATUS   = 6'h14;
  localparam logic [5:0] OFF_FIRST_UNUSED = 6'h18;

  // Replace the strobed byte lanes of old_v with the matching lanes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [63:0]      mtime_r, mtimecmp_r;
  logic [PW-1:0]    prescaler_r;
  logic [31:0]      hi_snap_r;
  logic [LED_W-1:0] led_r;
  logic             err_r, irq_r;

  logic             is_ram_s, is_mmio_s, mmio_wr_s, mtime_wr_s;
  logic [5:0]       off_s;
  logic [AW-1:0]    idx_s;
  logic [63:0]      mtime_next_s, cmp_next_s;
  logic [PW-1:0]    pre_next_s;
  logic [31:0]      led_word_s, led_merge_s, rdata_s;
  logic [LED_W-1:0] led_next_s;
  logic             err_set_s, err_clr_s, irq_next_s;

  // Address decode; RAM takes priority should the MMIO window ever overlap it.
  always_comb begin
    is_ram_s  = ({1'b0, dmAddrIn} < RAM_BYTES);
    is_mmio_s = !is_ram_s && (dmAddrIn[31:6] == MMIO_BASE[31:6]);
    off_s     = {dmAddrIn[5:2], 2'b00};
    idx_s     = dmAddrIn[AW+1:2];
    mmio_wr_s = dmWeIn && is_mmio_s && (dmDataWIn != 4'b0000);
  end

  // LED register widened to a bus word for reads and lane merging.
  always_comb begin
    led_word_s             = {32{1'b0}};
    led_word_s[LED_W-1:0]  = led_r;
    led_merge_s            = merge_bytes(led_word_s, dmWDataIn, dmDataWIn);
    led_next_s             = led_merge_s[LED_W-1:0];
  end

  // Timer next state: a store to either mtime half replaces the tick for
  // the whole 64-bit value and restarts the prescaler.
  always_comb begin
    mtime_next_s = mtime_r;
    pre_next_s   = prescaler_r;
    mtime_wr_s   = mmio_wr_s && ((off_s == OFF_MTIME_LO) || (off_s == OFF_MTIME_HI));
    if (mtime_wr_s) begin
      pre_next_s = {PW{1'b0}};
      if (off_s == OFF_MTIME_LO) begin
        mtime_next_s[31:0] = merge_bytes(mtime_r[31:0], dmWDataIn, dmDataWIn);
      end else begin
        mtime_next_s[63:32] = merge_bytes(mtime_r[63:32], dmWDataIn, dmDataWIn);
      end
    end else if (prescaler_r == PRE_MAX) begin
      pre_next_s   = {PW{1'b0}};
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      pre_next_s = prescaler_r + PW'(1);
    end
  end

  // Compare register updates, error set/clear terms and the interrupt level.
  always_comb begin
    cmp_next_s = mtimecmp_r;
    if (mmio_wr_s) begin
      case (off_s)
        OFF_CMP_LO: cmp_next_s[31:0]  = merge_bytes(mtimecmp_r[31:0], dmWDataIn, dmDataWIn);
        OFF_CMP_HI: cmp_next_s[63:32] = merge_bytes(mtimecmp_r[63:32], dmWDataIn, dmDataWIn);
        default:    cmp_next_s        = mtimecmp_r;
      endcase
    end else begin
      cmp_next_s = mtimecmp_r;
    end
    err_set_s  = ((dmWeIn || dmReIn) && !is_ram_s && !is_mmio_s) ||
                 (mmio_wr_s && (off_s >= OFF_FIRST_UNUSED));
    err_clr_s  = mmio_wr_s && (off_s == OFF_STATUS) && dmDataWIn[0] && dmWDataIn[1];
    irq_next_s = (mtime_next_s >= cmp_next_s);
  end

  // Read mux; the returned word is the state before any same-cycle store.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (dmReIn && is_ram_s) begin
      rdata_s = mem_r[idx_s];
    end else if (dmReIn && is_mmio_s) begin
      case (off_s)
        OFF_MTIME_LO: rdata_s = mtime_r[31:0];
        OFF_MTIME_HI: rdata_s = hi_snap_r;
        OFF_CMP_LO:   rdata_s = mtimecmp_r[31:0];
        OFF_CMP_HI:   rdata_s = mtimecmp_r[63:32];
        OFF_LED:      rdata_s = led_word_s;
        OFF_STATUS:   rdata_s = {30'h0, err_r, irq_r};
        default:      rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // RAM array: not reset, and stores are dropped while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && dmWeIn && is_ram_s) begin
      for (int b = 0; b < 4; b++) begin
        if (dmDataWIn[b]) begin
          mem_r[idx_s][8*b +: 8] <= dmWDataIn[8*b +: 8];
        end
      end
    end
  end

  // MMIO state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_r     <= 64'h0;
      mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescaler_r <= {PW{1'b0}};
      hi_snap_r   <= 32'h0;
      led_r       <= {LED_W{1'b0}};
      err_r       <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      mtime_r     <= mtime_next_s;
      mtimecmp_r  <= cmp_next_s;
      prescaler_r <= pre_next_s;
      // Latch the upper half as the lower half is read so a two-load read is tear-free.
      if (dmReIn && is_mmio_s && (off_s == OFF_MTIME_LO)) begin
        hi_snap_r <= mtime_r[63:32];
      end
      if (mmio_wr_s && (off_s == OFF_LED)) begin
        led_r <= led_next_s;
      end
      // A new error wins over a same-cycle clear.
      err_r <= err_set_s | (err_r & ~err_clr_s);
      irq_r <= irq_next_s;
    end
  end

  assign dmRDataOut  = rdata_s;
  assign timerIrqOut = irq_r;
  assign ledOut      = led_r;
  assign busErrOut   = err_r;

endmodule
